// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared lane count, lane index and FSM state types for demux_1x4_capture
package demux_pkg;

    localparam int LANES = 4;

    typedef logic [1:0] lane_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/demux_lane_decoder.sv
// rtl/demux_lane_decoder.sv - lane index plus valid to one-hot lane write enable
module demux_lane_decoder
    import demux_pkg::*;
(
    input  lane_t            control,
    input  logic             valid,
    output logic [LANES-1:0] we
);

    always_comb begin
        we = '0;
        if (valid) begin
            we = LANES'(1) << control;
        end
    end

endmodule

// File: rtl/demux_1x4_capture.sv
// rtl/demux_1x4_capture.sv - rebuilds a 4-lane word from a beat stream; DEMUX_SEQ_CHECK_EN enforces lane order 0,1,2,3
module demux_1x4_capture
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in,
    input  lane_t                  control,
    input  logic                   valid,
    output logic [LANES*WIDTH-1:0] out,
    output logic                   out_valid,
    output logic [LANES-1:0]       lane_mask,
    output logic                   seq_err
);

    logic [LANES-1:0]       we;
    logic [LANES-1:0]       mask_base;
    logic [LANES-1:0]       mask_next;
    logic [WIDTH-1:0]       cap [LANES];
    logic [LANES*WIDTH-1:0] word;
    logic                   order_ok;
    state_t                 state;

    demux_lane_decoder u_dec (
        .control (control),
        .valid   (valid),
        .we      (we)
    );

    // The word on the completing edge merges the incoming beat with the bank.
    always_comb begin
        mask_base = (state == FILL) ? lane_mask : '0;
        mask_next = mask_base | we;
        word      = '0;
        for (int i = 0; i < LANES; i++) begin
            word[i*WIDTH +: WIDTH] = we[i] ? in : cap[i];
        end
    end

`ifdef DEMUX_SEQ_CHECK_EN
    lane_t exp;

    assign order_ok = (control == exp);
`else
    assign order_ok = 1'b1;
    assign seq_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
            lane_mask <= '0;
            state     <= IDLE;
            for (int i = 0; i < LANES; i++) begin
                cap[i] <= '0;
            end
`ifdef DEMUX_SEQ_CHECK_EN
            seq_err   <= 1'b0;
            exp       <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
`ifdef DEMUX_SEQ_CHECK_EN
            seq_err   <= 1'b0;
`endif
            if (valid && !order_ok) begin
`ifdef DEMUX_SEQ_CHECK_EN
                // Out-of-order beat kills the partial word; lane 0 may legally start a new one.
                seq_err <= 1'b1;
                if (control == lane_t'(0)) begin
                    cap[0]    <= in;
                    lane_mask <= LANES'(1);
                    exp       <= lane_t'(1);
                    state     <= FILL;
                end else begin
                    lane_mask <= '0;
                    exp       <= '0;
                    state     <= IDLE;
                end
`endif
            end else if (valid) begin
                for (int i = 0; i < LANES; i++) begin
                    if (we[i]) begin
                        cap[i] <= in;
                    end
                end
                if (&mask_next) begin
                    out       <= word;
                    out_valid <= 1'b1;
                    lane_mask <= '0;
                    state     <= IDLE;
                end else begin
                    lane_mask <= mask_next;
                    state     <= FILL;
                end
`ifdef DEMUX_SEQ_CHECK_EN
                exp <= exp + lane_t'(1);
`endif
            end
        end
    end

endmodule

// File: tb/tb_demux_1x4_capture.sv
// tb/tb_demux_1x4_capture.sv - self-checking bench for demux_1x4_capture, both DEMUX_SEQ_CHECK_EN builds
module tb_demux_1x4_capture;

    localparam int W = 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   in;
    logic [1:0]     control;
    logic           valid;
    logic [4*W-1:0] out;
    logic           out_valid;
    logic [3:0]     lane_mask;
    logic           seq_err;

    demux_1x4_capture #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .control   (control),
        .valid     (valid),
        .out       (out),
        .out_valid (out_valid),
        .lane_mask (lane_mask),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: which lanes have arrived this word, their values, and the last delivered word.
    bit [W-1:0]   m_val [4];
    bit           m_have [4];
    bit [4*W-1:0] m_out;
    bit           m_ov;
    bit           m_err;
    int           ov_count;

    function automatic int lanes_held();
        int n = 0;
        for (int i = 0; i < 4; i++) n += m_have[i];
        return n;
    endfunction

    function automatic bit [3:0] held_mask();
        bit [3:0] m = '0;
        for (int i = 0; i < 4; i++) m[i] = m_have[i];
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".out"},       32'(out),       32'(m_out));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ".lane_mask"}, 32'(lane_mask), 32'(held_mask()));
        chk({tag, ".seq_err"},   32'(seq_err),   32'(m_err));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_val[i]  = '0;
            m_have[i] = 1'b0;
        end
        m_out = '0;
        m_ov  = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_beat(input bit v, input int c, input bit [W-1:0] d);
        m_ov  = 1'b0;
        m_err = 1'b0;
        if (!v) return;
`ifdef DEMUX_SEQ_CHECK_EN
        // In-order arrival means the next lane equals the number already held.
        if (c != lanes_held()) begin
            m_err = 1'b1;
            for (int i = 0; i < 4; i++) m_have[i] = 1'b0;
            if (c == 0) begin
                m_val[0]  = d;
                m_have[0] = 1'b1;
            end
            return;
        end
`endif
        m_val[c]  = d;
        m_have[c] = 1'b1;
        if (lanes_held() == 4) begin
            for (int i = 0; i < 4; i++) begin
                m_out[i*W +: W] = m_val[i];
                m_have[i] = 1'b0;
            end
            m_ov = 1'b1;
            ov_count++;
        end
    endtask

    task automatic cycle(input bit v, input int c, input bit [W-1:0] d);
        valid   = v;
        control = 2'(c);
        in      = d;
        @(posedge clk);
        model_beat(v, c, d);
        #1;
        compare_all("cyc");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        compare_all("rst");
        reset = 1'b0;
    endtask

    task automatic word4(input bit [3:0] w);
        for (int i = 0; i < 4; i++) cycle(1'b1, i, W'(w[i]));
    endtask

    initial begin
        reset   = 1'b1;
        valid   = 1'b0;
        control = '0;
        in      = '0;
        ov_count = 0;
        model_reset();
        @(posedge clk);
        do_reset();
        chk("reset_out_lit", 32'(out), 32'h0);

        // Word 1011 with explicit lane_mask progression.
        cycle(1'b1, 0, 1'b1); chk("mask_0001_lit", 32'(lane_mask), 32'h1);
        cycle(1'b1, 1, 1'b1); chk("mask_0011_lit", 32'(lane_mask), 32'h3);
        cycle(1'b1, 2, 1'b0); chk("mask_0111_lit", 32'(lane_mask), 32'h7);
        cycle(1'b1, 3, 1'b1);
        chk("word_1011_lit", 32'(out), 32'hb);
        chk("ov_1011_lit",   32'(out_valid), 32'h1);
        chk("mask_done_lit", 32'(lane_mask), 32'h0);

        // Back-to-back 0110; out must hold 1011 until its completion.
        cycle(1'b1, 0, 1'b0);
        chk("ov_drop_lit", 32'(out_valid), 32'h0);
        chk("hold_1011_lit", 32'(out), 32'hb);
        cycle(1'b1, 1, 1'b1);
        cycle(1'b1, 2, 1'b1);
        cycle(1'b1, 3, 1'b0);
        chk("word_0110_lit", 32'(out), 32'h6);
        cycle(1'b0, 0, 1'b0);

        // Reset mid-word, then 0101.
        cycle(1'b1, 0, 1'b1);
        cycle(1'b1, 1, 1'b0);
        do_reset();
        chk("reset_mid_out_lit", 32'(out), 32'h0);
        cycle(1'b0, 0, 1'b0);
        word4(4'b0101);
        chk("word_0101_lit", 32'(out), 32'h5);

        // Valid low five cycles inside a word.
        cycle(1'b1, 0, 1'b1);
        cycle(1'b1, 1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 3, 1'b0);
            chk("freeze_mask_lit", 32'(lane_mask), 32'h3);
        end
        cycle(1'b1, 2, 1'b1);
        cycle(1'b1, 3, 1'b1);
        chk("word_1111_lit", 32'(out), 32'hf);

`ifdef DEMUX_SEQ_CHECK_EN
        // 0,1,3: error on lane 3, word dropped.
        cycle(1'b1, 0, 1'b1);
        cycle(1'b1, 1, 1'b1);
        cycle(1'b1, 3, 1'b1);
        chk("err_013_lit", 32'(seq_err), 32'h1);
        chk("err_013_mask_lit", 32'(lane_mask), 32'h0);
        // 0,2
        cycle(1'b1, 0, 1'b1);
        cycle(1'b1, 2, 1'b1);
        chk("err_02_lit", 32'(seq_err), 32'h1);
        chk("err_02_mask_lit", 32'(lane_mask), 32'h0);
        // 0,1,0 restarts, then 1,2,3 completes.
        cycle(1'b1, 0, 1'b0);
        cycle(1'b1, 1, 1'b0);
        cycle(1'b1, 0, 1'b1);
        chk("err_010_lit", 32'(seq_err), 32'h1);
        chk("err_010_mask_lit", 32'(lane_mask), 32'h1);
        cycle(1'b1, 1, 1'b0);
        chk("err_clear_lit", 32'(seq_err), 32'h0);
        cycle(1'b1, 2, 1'b1);
        cycle(1'b1, 3, 1'b0);
        chk("restart_ov_lit", 32'(out_valid), 32'h1);
        chk("restart_word_lit", 32'(out), 32'h5);
`else
        // Out-of-order arrival 3,1,0,2 with in 1,0,0,1.
        cycle(1'b1, 3, 1'b1);
        cycle(1'b1, 1, 1'b0);
        cycle(1'b1, 0, 1'b0);
        cycle(1'b1, 2, 1'b1);
        chk("reorder_word_lit", 32'(out), 32'hc);
        chk("reorder_ov_lit", 32'(out_valid), 32'h1);
        // Lane 1 written 0 then 1.
        cycle(1'b1, 0, 1'b0);
        cycle(1'b1, 1, 1'b0);
        cycle(1'b1, 1, 1'b1);
        chk("dup_mask_lit", 32'(lane_mask), 32'h3);
        chk("dup_seq_err_lit", 32'(seq_err), 32'h0);
        cycle(1'b1, 2, 1'b0);
        cycle(1'b1, 3, 1'b0);
        chk("dup_lane1_lit", 32'(out[1*W +: W]), 32'h1);
        chk("dup_word_lit", 32'(out), 32'h2);
`endif
        cycle(1'b0, 0, 1'b0);
        chk("ov_total", 32'(ov_count),
`ifdef DEMUX_SEQ_CHECK_EN
            32'd5
`else
            32'd6
`endif
        );

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
